axi_id_issue_ctrl: RTL and testbench
====================================

// Module: axi_id_issue_ctrl
// PURPOSE
//  Issue gate/scheduler in front of the axi_id_in_flight_array on one AW or AR channel of the demux.
//  Accepts a request (ID + target select), queries the in-flight table and holds it if the ID is in
//  flight to a different master port or the total in-flight budget is exhausted.
//  On acceptance: pushes the ID into the table, then presents the request downstream with an
//  AXI-stable valid. Pops the table on each final response handshake.
// PARAMETERS
//  AxiLookBits  3   ID bits used to index the in-flight table
//  MaxTrans     8   max total outstanding transactions across all IDs
//  CntWidth     4   in-flight count width; must satisfy 2**CntWidth > MaxTrans
//  SelWidth     2   master-port select width
// PORTS
//  clk_i                         in   1            clock
//  rst_i                         in   1            synchronous reset, active-high
//  slv_req_valid_i               in   1            upstream request valid
//  slv_req_ready_o               out  1            upstream request ready
//  slv_req_id_i                  in   AxiLookBits  request ID (lookup bits)
//  slv_req_sel_i                 in   SelWidth     target master port
//  slv_req_atop_i                in   1            atomic with response (used only with macro)
//  mst_req_valid_o               out  1            downstream request valid
//  mst_req_ready_i               in   1            downstream request ready
//  mst_req_sel_o                 out  SelWidth     latched target select
//  lookup_axi_id_o               out  AxiLookBits  table lookup ID (= slv_req_id_i)
//  lookup_for_atomic_id_o        out  AxiLookBits  atomic lookup ID
//  lookup_sel_taken_i            in   1            table: ID has outstanding transactions
//  lookup_for_atomic_id_taken_i  in   1            table: atomic ID outstanding
//  lookup_sel_i                  in   SelWidth     table: select bound to the ID
//  in_flight_cnt_i               in   CntWidth     table: total outstanding count
//  push_en_o / push_axi_id_o / push_sel_o   out  1/AxiLookBits/SelWidth  table push
//  rsp_valid_i / rsp_ready_i     in   1/1          final response beat handshake (B, or R with last)
//  rsp_id_i                      in   AxiLookBits  response ID
//  pop_en_o / pop_axi_id_o       out  1/AxiLookBits  table pop
//  stall_cnt_o                   out  16           saturating count of stalled request cycles
// BEHAVIOUR
//  - Reset (rst_i=1 at a clock edge): state=IDLE.
//    mst_req_valid_o=0, mst_req_sel_o=0, push_en_o=0, stall_cnt_o=0.
//    slv_req_ready_o and pop_en_o follow their combinational rules (0 with no valid input).
//  - Reset mid-operation: a held downstream request is dropped without a pop; the integrator
//    resets the table in the same cycle.
//  - allowed = (!lookup_sel_taken_i || lookup_sel_i==slv_req_sel_i) && ({1'b0,in_flight_cnt_i} < MaxTrans).
//  - FSM IDLE: slv_req_ready_o = allowed. On slv handshake:
//    latch sel into mst_req_sel_o; push_en_o=1 the same cycle with the ID and sel; go ISSUE.
//  - FSM ISSUE: mst_req_valid_o=1, mst_req_sel_o stable until mst_req_ready_i.
//    slv_req_ready_o = mst_req_ready_i && allowed.
//    Handshake with new slv handshake in the same cycle: relatch, push, stay ISSUE (back-to-back).
//    Handshake without one: go IDLE.
//  - Lookup is combinational on slv_req_id_i; a push takes effect in the table the next cycle.
//    A same-ID follow-up request is therefore evaluated against the updated table.
//  - pop_en_o = rsp_valid_i & rsp_ready_i; pop_axi_id_o = rsp_id_i; zero latency, no state.
//  - Push and pop of the same ID in the same cycle: both asserted; the table nets zero.
//  - Budget full (cnt==MaxTrans): ready stays low; a pop in that cycle does not unblock until the next cycle.
//  - stall_cnt_o += 1 each cycle with slv_req_valid_i && !slv_req_ready_o; saturates at 16'hFFFF.
// CONFIGURATION
//  AXI_ID_ISSUE_ATOP_EN defined:
//    lookup_for_atomic_id_o = slv_req_id_i.
//    A request with slv_req_atop_i=1 additionally requires !lookup_sel_taken_i && !lookup_for_atomic_id_taken_i.
//  Not defined: slv_req_atop_i ignored; lookup_for_atomic_id_o tied '0; allowed as above.
// TESTING
//  1. Reset, one request id=2 sel=1, mst_ready=1
//     -> push id2/sel1 in accept cycle; mst_valid next cycle; pop on rsp id2.
//  2. id=3 in flight to sel0, new id=3 sel=2 -> slv_ready=0 and stall_cnt counts
//     until the pop of id3; accepted the cycle after the pop.
//  3. id=3 in flight to sel0, new id=3 sel=0 -> accepted without stall.
//  4. Fill to 8 outstanding distinct/same-sel IDs -> 9th stalled.
//     One pop -> 9th accepted the following cycle.
//  5. mst_ready low 5 cycles -> mst_valid and sel held stable.
//     With back-to-back slv valid: accept on the handshake cycle, no IDLE bubble.
//  6. With AXI_ID_ISSUE_ATOP_EN: atop=1 id=4 while atomic id 4 taken -> stalled.
//     Without the macro: same stimulus accepted.

Source files
------------

// File: rtl/axi_id_issue_ctrl.sv
// axi_id_issue_ctrl: in-flight-aware issue gate for one AW/AR demux channel.
// Define AXI_ID_ISSUE_ATOP_EN to also block atomics whose ID is outstanding.
module axi_id_issue_ctrl #(
    parameter int unsigned AxiLookBits = 3,
    parameter int unsigned MaxTrans    = 8,
    parameter int unsigned CntWidth    = 4,
    parameter int unsigned SelWidth    = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   slv_req_valid_i,
    output logic                   slv_req_ready_o,
    input  logic [AxiLookBits-1:0] slv_req_id_i,
    input  logic [SelWidth-1:0]    slv_req_sel_i,
    input  logic                   slv_req_atop_i,
    output logic                   mst_req_valid_o,
    input  logic                   mst_req_ready_i,
    output logic [SelWidth-1:0]    mst_req_sel_o,
    output logic [AxiLookBits-1:0] lookup_axi_id_o,
    output logic [AxiLookBits-1:0] lookup_for_atomic_id_o,
    input  logic                   lookup_sel_taken_i,
    input  logic                   lookup_for_atomic_id_taken_i,
    input  logic [SelWidth-1:0]    lookup_sel_i,
    input  logic [CntWidth-1:0]    in_flight_cnt_i,
    output logic                   push_en_o,
    output logic [AxiLookBits-1:0] push_axi_id_o,
    output logic [SelWidth-1:0]    push_sel_o,
    input  logic                   rsp_valid_i,
    input  logic                   rsp_ready_i,
    input  logic [AxiLookBits-1:0] rsp_id_i,
    output logic                   pop_en_o,
    output logic [AxiLookBits-1:0] pop_axi_id_o,
    output logic [15:0]            stall_cnt_o
);
    typedef enum logic {IDLE, ISSUE} state_t;
    localparam logic [CntWidth:0] MaxCnt = MaxTrans[CntWidth:0];
    state_t state;
    logic   allowed;
    logic   base_ok;
    assign base_ok = (!lookup_sel_taken_i || lookup_sel_i == slv_req_sel_i) &&
                     ({1'b0, in_flight_cnt_i} < MaxCnt);
`ifdef AXI_ID_ISSUE_ATOP_EN
    assign lookup_for_atomic_id_o = slv_req_id_i;
    assign allowed = base_ok &&
                     (!slv_req_atop_i || (!lookup_sel_taken_i && !lookup_for_atomic_id_taken_i));
`else
    logic unused_atop;
    assign unused_atop = slv_req_atop_i ^ lookup_for_atomic_id_taken_i;
    assign lookup_for_atomic_id_o = '0;
    assign allowed = base_ok;
`endif
    assign lookup_axi_id_o = slv_req_id_i;
    // a held request must leave before a new one can take its slot
    assign slv_req_ready_o = slv_req_valid_i && allowed && (state == IDLE || mst_req_ready_i);
    assign push_en_o       = slv_req_ready_o;
    assign push_axi_id_o   = slv_req_id_i;
    assign push_sel_o      = slv_req_sel_i;
    assign pop_en_o        = rsp_valid_i && rsp_ready_i;
    assign pop_axi_id_o    = rsp_id_i;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            mst_req_valid_o <= 1'b0;
            mst_req_sel_o   <= '0;
            stall_cnt_o     <= '0;
        end else begin
            if (push_en_o) begin
                state           <= ISSUE;
                mst_req_valid_o <= 1'b1;
                mst_req_sel_o   <= slv_req_sel_i;
            end else if (state == ISSUE && mst_req_ready_i) begin
                state           <= IDLE;
                mst_req_valid_o <= 1'b0;
            end
            if (slv_req_valid_i && !slv_req_ready_o && stall_cnt_o != 16'hFFFF)
                stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
endmodule

// File: tb/tb_axi_id_issue_ctrl.sv
// tb_axi_id_issue_ctrl: vector table, directed sequences and random traffic against
// a request-level model plus a behavioural in-flight table.
module tb_axi_id_issue_ctrl;
    logic clk = 1'b0, clk_en = 1'b1, rst = 1'b0;
    logic v = 0, atop = 0, mrdy = 0, rv = 0, rr = 0;
    logic [2:0] id = 0, rid = 0;
    logic [1:0] sel = 0;
    logic taken, atake;
    logic [1:0] lsel;
    logic [3:0] cnt;
    logic ovr = 0, o_taken = 0, o_atake = 0;
    logic [1:0] o_lsel = 0;
    logic [3:0] o_cnt = 0;
    logic slv_req_ready_o, mst_req_valid_o, push_en_o, pop_en_o;
    logic [1:0] mst_req_sel_o, push_sel_o;
    logic [2:0] lookup_axi_id_o, lookup_for_atomic_id_o, push_axi_id_o, pop_axi_id_o;
    logic [15:0] stall_cnt_o;
    int tcnt [8];
    logic [1:0] tsel [8];
    int total_in = 0;
    logic m_held = 0;
    logic [1:0] m_sel = 0;
    int m_stall = 0;
    int total = 0, bad = 0;

    always #5 if (clk_en) clk = ~clk;

    always_comb begin
        taken = ovr ? o_taken : (tcnt[id] != 0);
        lsel  = ovr ? o_lsel  : tsel[id];
        cnt   = ovr ? o_cnt   : total_in[3:0];
        atake = ovr ? o_atake : (tcnt[lookup_for_atomic_id_o] != 0);
    end

    axi_id_issue_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .slv_req_valid_i(v), .slv_req_ready_o(slv_req_ready_o),
        .slv_req_id_i(id), .slv_req_sel_i(sel), .slv_req_atop_i(atop),
        .mst_req_valid_o(mst_req_valid_o), .mst_req_ready_i(mrdy), .mst_req_sel_o(mst_req_sel_o),
        .lookup_axi_id_o(lookup_axi_id_o), .lookup_for_atomic_id_o(lookup_for_atomic_id_o),
        .lookup_sel_taken_i(taken), .lookup_for_atomic_id_taken_i(atake),
        .lookup_sel_i(lsel), .in_flight_cnt_i(cnt),
        .push_en_o(push_en_o), .push_axi_id_o(push_axi_id_o), .push_sel_o(push_sel_o),
        .rsp_valid_i(rv), .rsp_ready_i(rr), .rsp_id_i(rid),
        .pop_en_o(pop_en_o), .pop_axi_id_o(pop_axi_id_o), .stall_cnt_o(stall_cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic allowed_now();
        logic ok;
        ok = (!taken || lsel == sel) && cnt < 4'd8;
`ifdef AXI_ID_ISSUE_ATOP_EN
        if (atop && (taken || atake)) ok = 0;
`endif
        return ok;
    endfunction

    task automatic cycle();
        logic er, epop;
        #1;
        er   = v && allowed_now() && (!m_held || mrdy);
        epop = rv && rr;
        chk("ready", {31'd0, slv_req_ready_o}, {31'd0, er});
        chk("push", {31'd0, push_en_o}, {31'd0, er});
        if (er) begin
            chk("push_id", {29'd0, push_axi_id_o}, {29'd0, id});
            chk("push_sel", {30'd0, push_sel_o}, {30'd0, sel});
        end
        chk("lookup_id", {29'd0, lookup_axi_id_o}, {29'd0, id});
        chk("mst_valid", {31'd0, mst_req_valid_o}, {31'd0, m_held});
        chk("mst_sel", {30'd0, mst_req_sel_o}, {30'd0, m_sel});
        chk("pop", {31'd0, pop_en_o}, {31'd0, epop});
        if (epop) chk("pop_id", {29'd0, pop_axi_id_o}, {29'd0, rid});
        chk("stall", {16'd0, stall_cnt_o}, m_stall);
        @(posedge clk);
        #1;
        if (er) begin tcnt[id]++; tsel[id] = sel; total_in++; end
        if (epop) begin tcnt[rid]--; total_in--; end
        if (v && !er && m_stall < 65535) m_stall++;
        if (er) begin m_held = 1; m_sel = sel; end
        else if (mrdy) m_held = 0;
    endtask

    task automatic do_reset();
        rst = 1; v = 0; atop = 0; mrdy = 0; rv = 0; rr = 0; id = 0; sel = 0; rid = 0;
        @(posedge clk);
        #1;
        rst = 0;
        m_held = 0; m_sel = 0; m_stall = 0; total_in = 0;
        for (int i = 0; i < 8; i++) begin tcnt[i] = 0; tsel[i] = 0; end
        chk("rst_mvalid", {31'd0, mst_req_valid_o}, 0);
        chk("rst_msel", {30'd0, mst_req_sel_o}, 0);
        chk("rst_push", {31'd0, push_en_o}, 0);
        chk("rst_stall", {16'd0, stall_cnt_o}, 0);
        chk("rst_ready", {31'd0, slv_req_ready_o}, 0);
        chk("rst_pop", {31'd0, pop_en_o}, 0);
    endtask

    typedef struct {
        logic v; logic [1:0] sel; logic tk; logic [1:0] ls; logic [3:0] c;
        logic rv; logic rr; logic [2:0] rid;
        logic e_rdy; logic e_push; logic e_pop;
    } vec_t;
    vec_t vecs [10];

    initial begin
        vecs[0] = '{1, 0, 0, 0, 4'd0,  0, 0, 0, 1, 1, 0};
        vecs[1] = '{1, 1, 1, 1, 4'd3,  0, 0, 0, 1, 1, 0};
        vecs[2] = '{1, 2, 1, 0, 4'd3,  0, 0, 0, 0, 0, 0};
        vecs[3] = '{1, 3, 0, 2, 4'd7,  0, 0, 0, 1, 1, 0};
        vecs[4] = '{1, 3, 0, 2, 4'd8,  0, 0, 0, 0, 0, 0};
        vecs[5] = '{0, 0, 0, 0, 4'd0,  0, 0, 0, 0, 0, 0};
        vecs[6] = '{1, 3, 1, 3, 4'd8,  0, 0, 0, 0, 0, 0};
        vecs[7] = '{0, 0, 0, 0, 4'd2,  1, 1, 5, 0, 0, 1};
        vecs[8] = '{0, 0, 0, 0, 4'd2,  1, 0, 5, 0, 0, 0};
        vecs[9] = '{1, 1, 0, 0, 4'd15, 0, 1, 2, 0, 0, 0};

        do_reset();
        // freeze the clock so every vector sees the idle state
        clk_en = 0; ovr = 1;
        for (int i = 0; i < 10; i++) begin
            v = vecs[i].v; sel = vecs[i].sel; id = 3'(i);
            o_taken = vecs[i].tk; o_lsel = vecs[i].ls; o_cnt = vecs[i].c;
            rv = vecs[i].rv; rr = vecs[i].rr; rid = vecs[i].rid;
            #1;
            chk($sformatf("vec%0d_ready", i), {31'd0, slv_req_ready_o}, {31'd0, vecs[i].e_rdy});
            chk($sformatf("vec%0d_push", i), {31'd0, push_en_o}, {31'd0, vecs[i].e_push});
            chk($sformatf("vec%0d_pop", i), {31'd0, pop_en_o}, {31'd0, vecs[i].e_pop});
            if (vecs[i].e_pop) chk($sformatf("vec%0d_pop_id", i), {29'd0, pop_axi_id_o}, {29'd0, vecs[i].rid});
        end
        ovr = 0; clk_en = 1;

        // single request, issue, response
        do_reset();
        v = 1; id = 2; sel = 1; mrdy = 1; cycle();
        v = 0; cycle();
        rv = 1; rr = 1; rid = 2; cycle();
        rv = 0; rr = 0; cycle();
        chk("s1_table_empty", total_in, 0);

        // same ID to another port waits for the pop
        do_reset();
        v = 1; id = 3; sel = 0; mrdy = 1; cycle();
        sel = 2; repeat (3) cycle();
        rv = 1; rr = 1; rid = 3; cycle();
        chk("s2_stall", {16'd0, stall_cnt_o}, 4);
        rv = 0; rr = 0; cycle();
        chk("s2_msel", {30'd0, mst_req_sel_o}, 2);
        v = 0; cycle();

        // same ID to same port goes back-to-back
        do_reset();
        v = 1; id = 3; sel = 0; mrdy = 1; cycle(); cycle();
        chk("s3_stall", {16'd0, stall_cnt_o}, 0);
        chk("s3_count", total_in, 2);
        v = 0; cycle();

        // budget exhaustion
        do_reset();
        mrdy = 1; v = 1; sel = 1;
        for (int i = 0; i < 8; i++) begin id = 3'(i); cycle(); end
        id = 0; cycle();
        rv = 1; rr = 1; rid = 5; cycle();
        chk("s4_stall", {16'd0, stall_cnt_o}, 2);
        rv = 0; rr = 0; cycle();
        chk("s4_count", total_in, 8);
        v = 0; cycle();

        // downstream backpressure then handshake with back-to-back accept
        do_reset();
        mrdy = 0; v = 1; id = 1; sel = 2; cycle();
        v = 0;
        repeat (5) begin
            cycle();
            chk("s5_hold_valid", {31'd0, mst_req_valid_o}, 1);
            chk("s5_hold_sel", {30'd0, mst_req_sel_o}, 2);
        end
        v = 1; id = 6; sel = 3; mrdy = 1; cycle();
        chk("s5_b2b_valid", {31'd0, mst_req_valid_o}, 1);
        chk("s5_b2b_sel", {30'd0, mst_req_sel_o}, 3);
        v = 0; cycle();
        chk("s5_idle", {31'd0, mst_req_valid_o}, 0);

        // atomic on an outstanding ID
        do_reset();
        v = 1; id = 4; sel = 0; mrdy = 1; cycle();
        atop = 1;
        #1;
`ifdef AXI_ID_ISSUE_ATOP_EN
        chk("s6_atop_ready", {31'd0, slv_req_ready_o}, 0);
`else
        chk("s6_atop_ready", {31'd0, slv_req_ready_o}, 1);
`endif
        cycle();
        atop = 0; v = 0; cycle();

        // random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            v = 1'($urandom_range(0, 1)); id = 3'($urandom); sel = 2'($urandom);
            atop = ($urandom_range(0, 7) == 0); mrdy = ($urandom_range(0, 3) != 0);
            rid = 3'($urandom);
            rv = (tcnt[rid] > 0) && ($urandom_range(0, 2) != 0);
            rr = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
